aes_key_schedule_engine: RTL and testbench
==========================================

// Module: aes_key_schedule_engine
// PURPOSE
// - Iterative AES key expansion for AES-128/192/256, mode selected at run time. Generates one 32-bit word per cycle with a single shared 4-byte S-box.
// - Stores all round keys in an internal buffer. The cipher/decipher datapath reads any round key by index, in forward or reverse order.
// - Sits between the key-load interface and the round datapath. Supersedes the fixed AES-128, round-at-a-time key path.
// PARAMETERS
// - MAX_NK, default 8: largest supported key length in 32-bit words. Legal values: 4, 6, 8. Modes needing Nk > MAX_NK are rejected.
// - RD_REG, default 1: 1 = registered read port (1-cycle latency); 0 = combinational read.
// PORTS
// - clk       in   1    clock, rising edge
// - areset    in   1    asynchronous, active-low reset
// - start     in   1    single-cycle request; samples key_in and key_len
// - key_len   in   2    00=AES-128 (Nk4,Nr10), 01=AES-192 (Nk6,Nr12), 10=AES-256 (Nk8,Nr14), 11=reserved
// - key_in    in   256  cipher key; w0=key_in[255:224]; shorter keys use the upper bits, lower bits ignored
// - busy      out  1    expansion in progress
// - done      out  1    1-cycle pulse when the schedule is complete
// - err       out  1    1-cycle pulse: start rejected (key_len=11 or Nk>MAX_NK)
// - key_ready out  1    buffer holds a valid schedule for the current mode
// - nr        out  4    round count of the stored schedule (10/12/14); 0 when not ready
// - rd_idx    in   4    round-key index, 0..nr
// - rd_key    out  128  {w[4i],w[4i+1],w[4i+2],w[4i+3]}
// - rd_valid  out  1    rd_key is valid for rd_idx
// BEHAVIOUR
// - Reset (areset=0, asynchronous): FSM=IDLE. busy, done, err, key_ready, rd_valid = 0. nr=0. rd_key=0. Buffer contents are don't-care. Reset mid-expansion aborts cleanly.
// - Word format: byte 0 is in [31:24]. RotWord {b0,b1,b2,b3}->{b1,b2,b3,b0}. SubWord applies the S-box bytewise.
// - Rcon[j], j=1..10 = 01,02,04,08,10,20,40,80,1B,36, placed in [31:24].
// - Expansion for i = Nk .. 4*(Nr+1)-1:
//   - t = w[i-1].
//   - If i mod Nk = 0: t = SubWord(RotWord(t)) ^ Rcon[i/Nk].
//   - Else if Nk = 8 and i mod 8 = 4: t = SubWord(t).
//   - w[i] = w[i-Nk] ^ t.
// - FSM:
//   - IDLE: on start with a legal mode go to LOAD. key_ready<=0, busy<=1.
//   - IDLE: on start with an illegal mode, err=1 for 1 cycle and stay in IDLE. key_ready and the stored schedule are unchanged.
//   - LOAD (1 cycle): write w0..w(Nk-1) from the latched key. i<=Nk. Go to EXPAND.
//   - EXPAND: write one word per cycle, i<=i+1. After writing the last word (43/51/59) go to DONE.
//   - DONE (1 cycle): done=1, busy<=0, key_ready<=1, nr<=Nr. Go to IDLE.
// - Latency: start sampled at edge E. done is high in the cycle after edge E+42 (AES-128), E+48 (AES-192), E+54 (AES-256).
// - start while busy or in DONE: ignored. No err, no restart.
// - start in the same cycle as done: accepted on the next IDLE cycle only if held. start is a pulse, so it is normally dropped; the issuer waits for done.
// - Read port:
//   - RD_REG=1: rd_key and rd_valid update 1 cycle after rd_idx.
//   - rd_valid = key_ready and rd_idx <= nr. Otherwise rd_key = 0 and rd_valid = 0.
//   - Reads during busy return 0 / invalid.
// - Counter i is 6 bits. i/Nk and i mod Nk come from a rolling sub-counter (0..Nk-1) plus a Rcon index that increments on wrap. No divider.
// TESTING
// - AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> done at E+42. rd_idx=10 -> d014f9a8 c9ee2589 e13f0cc8 b6630ca6. rd_idx=1 -> a0fafe17 88542cb1 23a33939 2a6c7605.
// - AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> done at E+48, nr=12. rd_idx=12 -> e98ba06f 448c773c 8ecc7204 01002202.
// - AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> done at E+54, nr=14. rd_idx=14 -> fe4890d1 e6188d0b 046df344 706c631e.
// - Reverse read after AES-128: rd_idx 10..0 back-to-back -> each key valid 1 cycle later. rd_idx=11 -> rd_valid=0, rd_key=0.
// - key_len=11 start -> err pulse, busy stays 0, prior schedule still readable. start pulsed mid-expansion -> ignored, same done timing.
// - areset low at cycle 20 of an AES-256 run -> all outputs 0 immediately. New AES-128 start -> correct keys, done at E+42.

Source files
------------

// File: rtl/aes_key_schedule_engine.sv
// Iterative AES-128/192/256 key expansion, one word per cycle.
// Round keys are held in an internal buffer and read by round index.
module aes_key_schedule_engine #(
    parameter int MAX_NK = 8,
    parameter bit RD_REG = 1
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         key_ready,
    output logic [3:0]   nr,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid
);

    localparam int         DEPTH_N = 4 * (MAX_NK + 7);
    localparam logic [6:0] DEPTH   = 7'(DEPTH_N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_FIN} state_t;

    state_t         state, state_nxt;
    logic [255:0]   key_q;
    logic [3:0]     nk_q, nrp_q;
    logic [5:0]     i_q;
    logic [2:0]     sub_q;
    logic [3:0]     rj_q;
    logic [31:0]    kbuf [DEPTH_N];

    logic [3:0]     req_nk, req_nr;
    logic           req_ok;
    logic           accept, reject, ld_en, exp_en, last;
    logic [31:0]    w_prev, w_nk, s_in, s_out, t, new_w;
    logic           rd_ok;
    logic [127:0]   rd_data;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = '0;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, p, b;
        r = 8'h01;
        p = x;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        logic [7:0] r;
        case (j)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rd_word(input logic [5:0] a);
        return ({1'b0, a} < DEPTH) ? kbuf[a] : '0;
    endfunction

    always_comb begin
        req_nk = 4'd4;
        req_nr = 4'd10;
        unique case (key_len)
            2'b00: begin req_nk = 4'd4; req_nr = 4'd10; end
            2'b01: begin req_nk = 4'd6; req_nr = 4'd12; end
            2'b10: begin req_nk = 4'd8; req_nr = 4'd14; end
            2'b11: begin req_nk = 4'd8; req_nr = 4'd14; end
        endcase
        req_ok = (key_len != 2'b11) && (int'(req_nk) <= MAX_NK);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (accept) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_EXPAND;
            S_EXPAND: if (last) state_nxt = S_FIN;
            S_FIN:    state_nxt = S_IDLE;
        endcase
    end

    // done is still high in the first IDLE cycle, so a start there is ignored
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (state == S_IDLE && !done && start) begin
            accept = req_ok;
            reject = !req_ok;
        end
        ld_en  = (state == S_LOAD);
        exp_en = (state == S_EXPAND);
        last   = (i_q == {nrp_q, 2'b11});
    end

    always_comb begin
        w_prev = rd_word(i_q - 6'd1);
        w_nk   = rd_word(i_q - {2'b00, nk_q});
        s_in   = (sub_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        s_out  = sub_word(s_in);
        if (sub_q == 3'd0)
            t = s_out ^ {rcon(rj_q), 24'h0};
        else if (nk_q == 4'd8 && sub_q == 3'd4)
            t = s_out;
        else
            t = w_prev;
        new_w = w_nk ^ t;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            key_q     <= '0;
            nk_q      <= 4'd4;
            nrp_q     <= 4'd10;
            i_q       <= '0;
            sub_q     <= '0;
            rj_q      <= 4'd1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            key_ready <= 1'b0;
            nr        <= '0;
        end else begin
            err  <= reject;
            done <= (state == S_FIN);
            if (accept) begin
                key_q     <= key_in;
                nk_q      <= req_nk;
                nrp_q     <= req_nr;
                busy      <= 1'b1;
                key_ready <= 1'b0;
                nr        <= '0;
            end
            if (ld_en) begin
                i_q   <= {2'b00, nk_q};
                sub_q <= '0;
                rj_q  <= 4'd1;
            end
            // sub_q tracks i mod Nk, rj_q tracks i / Nk
            if (exp_en) begin
                i_q <= i_q + 6'd1;
                if ({1'b0, sub_q} == nk_q - 4'd1) begin
                    sub_q <= '0;
                    rj_q  <= rj_q + 4'd1;
                end else begin
                    sub_q <= sub_q + 3'd1;
                end
            end
            if (state == S_FIN) begin
                busy      <= 1'b0;
                key_ready <= 1'b1;
                nr        <= nrp_q;
            end
        end
    end

    for (genvar a = 0; a < DEPTH_N; a++) begin : g_buf
        if (a < 8) begin : g_key
            always_ff @(posedge clk) begin
                if (ld_en && 4'(a) < nk_q)
                    kbuf[a] <= key_q[255-32*a -: 32];
                else if (exp_en && i_q == 6'(a))
                    kbuf[a] <= new_w;
            end
        end else begin : g_exp
            always_ff @(posedge clk) begin
                if (exp_en && i_q == 6'(a))
                    kbuf[a] <= new_w;
            end
        end
    end

    always_comb begin
        rd_ok   = key_ready && (rd_idx <= nr);
        rd_data = '0;
        if (rd_ok)
            rd_data = {rd_word({rd_idx, 2'd0}), rd_word({rd_idx, 2'd1}),
                       rd_word({rd_idx, 2'd2}), rd_word({rd_idx, 2'd3})};
    end

    if (RD_REG) begin : g_rd_reg
        always_ff @(posedge clk or negedge areset) begin
            if (!areset) begin
                rd_key   <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_key   <= rd_data;
                rd_valid <= rd_ok;
            end
        end
    end else begin : g_rd_comb
        assign rd_key   = rd_data;
        assign rd_valid = rd_ok;
    end

endmodule

// File: tb/tb_aes_key_schedule_engine.sv
// Scoreboard bench for aes_key_schedule_engine using FIPS-197 vectors.
// Stimulus queues expected done/err/read responses; a monitor checks them.
module tb_aes_key_schedule_engine;

    logic         clk = 1'b0;
    logic         areset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = '0;
    logic         busy, done, err, key_ready;
    logic [3:0]   nr;
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;
    logic         rd_valid;

    aes_key_schedule_engine dut (
        .clk       (clk),
        .areset    (areset),
        .start     (start),
        .key_len   (key_len),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .key_ready (key_ready),
        .nr        (nr),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] nr;
    } done_e_t;

    typedef struct {
        int           cyc;
        int           idx;
        logic         v;
        logic [127:0] k;
    } rd_e_t;

    done_e_t done_q[$];
    int      err_q[$];
    rd_e_t   rd_q[$];
    done_e_t de;
    rd_e_t   re;
    int      ee;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                     128'hffeeddccbbaa99887766554433221100};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'hdeadbeef01234567};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] rk128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic chk(input bit ok, input string nm,
                       input logic [131:0] got, input logic [131:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] kl, input logic [255:0] k, input int off,
                      input logic [3:0] enr, input bit push_done, input bit push_err);
        done_e_t d;
        key_len = kl;
        key_in  = k;
        start   = 1'b1;
        if (push_done) begin
            d.cyc = cyc + 1 + off;
            d.nr  = enr;
            done_q.push_back(d);
        end
        if (push_err) err_q.push_back(cyc + 1);
        tick();
        start  = 1'b0;
        key_in = '0;
    endtask

    task automatic rd(input int idx, input logic v, input logic [127:0] k);
        rd_e_t e;
        rd_idx = 4'(idx);
        e.cyc = cyc + 1;
        e.idx = idx;
        e.v   = v;
        e.k   = k;
        rd_q.push_back(e);
        tick();
    endtask

    task automatic wait_done(input string nm);
        int n0 = done_cnt;
        int k = 0;
        while (done_cnt == n0 && k < 200) begin
            tick();
            k++;
        end
        chk(done_cnt != n0, nm, 132'(k), 132'(200));
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                chk(1'b0, "done_unexpected", 132'(cyc), 132'(0));
            end else begin
                de = done_q.pop_front();
                chk(cyc == de.cyc, "done_cycle", 132'(cyc), 132'(de.cyc));
                chk(nr == de.nr && key_ready, "done_nr_ready",
                    {127'(nr), key_ready}, {127'(de.nr), 1'b1});
            end
        end
        if (err) begin
            if (err_q.size() == 0) begin
                chk(1'b0, "err_unexpected", 132'(cyc), 132'(0));
            end else begin
                ee = err_q.pop_front();
                chk(cyc == ee, "err_cycle", 132'(cyc), 132'(ee));
            end
        end
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            re = rd_q.pop_front();
            chk(1'b0, "rd_missed", 132'(cyc), 132'(re.cyc));
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            re = rd_q.pop_front();
            chk(rd_valid == re.v && rd_key == re.k,
                $sformatf("rd_key[%0d]", re.idx),
                {3'b0, rd_valid, rd_key}, {3'b0, re.v, re.k});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        chk(busy == 0 && done == 0 && err == 0, "reset_flags",
            {busy, done, err}, 3'b000);
        chk(key_ready == 0 && nr == 0, "reset_ready_nr",
            {key_ready, nr}, 5'b0);
        chk(rd_valid == 0 && rd_key == 0, "reset_rd",
            {rd_valid, rd_key}, 129'b0);
        areset = 1'b1;
        tick();

        go(2'b00, K128, 42, 4'd10, 1'b1, 1'b0);
        chk(busy == 1 && key_ready == 0, "busy_128", {busy, key_ready}, 2'b10);
        wait_done("wait_done_128");
        rd(1, 1'b1, rk128[1]);
        rd(10, 1'b1, rk128[10]);
        for (int i = 10; i >= 0; i--) rd(i, 1'b1, rk128[i]);
        rd(11, 1'b0, '0);
        rd(15, 1'b0, '0);
        tick();

        go(2'b11, K256, 0, 4'd0, 1'b0, 1'b1);
        tick();
        chk(busy == 0 && key_ready == 1 && nr == 10, "err_keeps_state",
            {busy, key_ready, nr}, {1'b0, 1'b1, 4'd10});
        rd(10, 1'b1, rk128[10]);
        tick();

        go(2'b01, K192, 48, 4'd12, 1'b1, 1'b0);
        repeat (9) tick();
        chk(busy == 1, "busy_192", 132'(busy), 132'(1));
        key_len = 2'b00;
        key_in  = K128;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        rd(0, 1'b0, '0);
        wait_done("wait_done_192");
        rd(12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
        rd(0, 1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5);
        rd(13, 1'b0, '0);
        tick();

        go(2'b10, K256, 54, 4'd14, 1'b1, 1'b0);
        wait_done("wait_done_256");
        rd(14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(1, 1'b1, 128'h1f352c073b6108d72d9810a30914dff4);
        rd(15, 1'b0, '0);
        tick();

        go(2'b10, K256, 0, 4'd0, 1'b0, 1'b0);
        repeat (19) tick();
        chk(busy == 1, "busy_before_abort", 132'(busy), 132'(1));
        areset = 1'b0;
        #1;
        chk(busy == 0 && done == 0 && err == 0 && key_ready == 0 && nr == 0,
            "abort_flags", {busy, done, err, key_ready, nr}, 8'b0);
        chk(rd_valid == 0 && rd_key == 0, "abort_rd",
            {rd_valid, rd_key}, 129'b0);
        tick();
        areset = 1'b1;
        tick();
        rd(10, 1'b0, '0);
        tick();

        go(2'b00, K128, 42, 4'd10, 1'b1, 1'b0);
        wait_done("wait_done_after_abort");
        rd(10, 1'b1, rk128[10]);
        rd(1, 1'b1, rk128[1]);
        rd(5, 1'b1, rk128[5]);
        repeat (3) tick();

        chk(done_q.size() == 0, "done_q_drained", 132'(done_q.size()), 132'(0));
        chk(err_q.size() == 0, "err_q_drained", 132'(err_q.size()), 132'(0));
        chk(rd_q.size() == 0, "rd_q_drained", 132'(rd_q.size()), 132'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
